// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer: pops DATA_W-bit words from a show-ahead FIFO and streams them as OUT_W-bit chunks, LSB chunk first.
// Latency: the first chunk is valid the cycle after the pop edge; consecutive words follow with no bubble.
// Backpressure: a chunk is held stable while out_ready_i is low; the next pop happens only with the last accepted chunk.
module fifo_drain_serializer #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] pop_data_i,
  output logic              pop_o,
  output logic              out_valid_o,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  // DATA_W must be an integer multiple of OUT_W; BEATS==1 degenerates to a registered pass-through.
  localparam int BEATS = DATA_W / OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept;
  logic at_last;
  logic last_acc;
  logic pop;

  // Handshake decode; pop is gated by reset so the FIFO never advances while reset is held.
  always_comb begin
    accept   = (state == SEND) & out_ready_i;
    at_last  = (cnt_q == LAST_CNT);
    last_acc = accept & at_last;
    pop      = reset & ~empty_i & ((state == IDLE) | last_acc);
  end

  // Word holder and beat counter: load on pop, shift on a non-final accept, go idle when drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (pop) begin
      // Covers both IDLE->SEND and the zero-bubble reload on the last chunk.
      state   <= SEND;
      cnt_q   <= '0;
      shift_q <= pop_data_i;
    end else if (last_acc) begin
      // Final chunk taken and nothing queued behind it.
      state   <= IDLE;
    end else if (accept) begin
      shift_q <= shift_q >> OUT_W;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Outputs come straight from state registers, so they clear the instant reset asserts.
  always_comb begin
    pop_o       = pop;
    out_valid_o = (state == SEND);
    busy_o      = (state == SEND);
    out_data_o  = shift_q[OUT_W-1:0];
    out_last_o  = (state == SEND) & at_last;
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// tb_fifo_drain_serializer: drives the serializer from a queue-based FIFO and checks every cycle against a chunk-queue model.
// Latency: outputs are sampled one time unit after the falling edge, once inputs for the next rising edge have settled.
// Backpressure: out_ready_i is driven per cycle, from directed patterns or from $urandom.
module tb_fifo_drain_serializer;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 2;
  localparam int BEATS  = DATA_W / OUT_W;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              empty_i;
  logic [DATA_W-1:0] pop_data_i;
  logic              pop_o;
  logic              out_valid_o;
  logic [OUT_W-1:0]  out_data_o;
  logic              out_last_o;
  logic              out_ready_i;
  logic              busy_o;

  always #5 clk = ~clk;

  fifo_drain_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .empty_i    (empty_i),
    .pop_data_i (pop_data_i),
    .pop_o      (pop_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] fifo_q[$];   // FIFO contents, head at index 0
  int                rem[$];      // chunks of the held word still to be sent
  int                got[$];      // accepted chunks (DUT data)
  int                got_cyc[$];  // cycle index of each accepted chunk
  int                pops = 0;
  int                cyc = 0;
  int                stall_hold = 0;

  int exp16[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo();
    empty_i    = (fifo_q.size() == 0);
    pop_data_i = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
  endtask

  // One clock cycle: drive, compare against the chunk-queue model, then advance model and FIFO on the edge.
  task automatic cycle(input bit rdy);
    bit exp_valid, exp_pop, m_acc;
    logic [DATA_W-1:0] w;
    @(negedge clk);
    out_ready_i = rdy;
    drive_fifo();
    #1;
    exp_valid = (rst_n == 1'b1) && (rem.size() > 0);
    exp_pop   = (rst_n == 1'b1) && !empty_i &&
                ((rem.size() == 0) || (rdy && rem.size() == 1));
    chk("pop", int'(pop_o), int'(exp_pop));
    chk("valid", int'(out_valid_o), int'(exp_valid));
    chk("busy", int'(busy_o), int'(exp_valid));
    chk("last", int'(out_last_o), int'(exp_valid && rem.size() == 1));
    if (exp_valid) chk("data", int'(out_data_o), rem[0]);
    if (empty_i) chk("no_pop_when_empty", int'(pop_o), 0);
    if (out_valid_o && rdy) begin
      got.push_back(int'(out_data_o));
      got_cyc.push_back(cyc);
    end
    if (out_valid_o && !rdy && out_data_o == 2'd1) stall_hold++;
    if (pop_o) pops++;
    m_acc = exp_valid && rdy;
    w = pop_data_i;
    @(posedge clk);
    if (m_acc) void'(rem.pop_front());
    if (exp_pop) begin
      rem.delete();
      for (int b = 0; b < BEATS; b++) rem.push_back(int'((w >> (OUT_W * b)) & ((1 << OUT_W) - 1)));
    end
    if (pop_o && fifo_q.size() > 0) void'(fifo_q.pop_front());
    cyc++;
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
    pops = 0;
    stall_hold = 0;
  endtask

  // Compares the accepted-chunk log against a literal list and checks the chunks arrived back to back.
  task automatic check_seq(input string name, input int n, input int e[16], input bit contiguous);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({name, "_chunk"}, got[i], e[i]);
      if (contiguous) chk({name, "_gapless"}, got_cyc[i] - got_cyc[0], i);
    end
  endtask

  task automatic check_quiet(input string name);
    #1;
    chk({name, "_pop"}, int'(pop_o), 0);
    chk({name, "_valid"}, int'(out_valid_o), 0);
    chk({name, "_data"}, int'(out_data_o), 0);
    chk({name, "_last"}, int'(out_last_o), 0);
    chk({name, "_busy"}, int'(busy_o), 0);
  endtask

  initial begin
    out_ready_i = 1'b0;
    rst_n = 1'b0;
    drive_fifo();
    check_quiet("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty FIFO for 20 cycles.
    clear_log();
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)));
    chk("empty_pops", pops, 0);
    chk("empty_chunks", got.size(), 0);

    // Single word 0xB4 -> 0,1,3,2.
    clear_log();
    push(8'hB4);
    for (int i = 0; i < 8; i++) cycle(1'b1);
    exp16 = '{0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("single", 4, exp16, 1'b1);
    chk("single_pops", pops, 1);
    chk("single_first_latency", (got_cyc.size() > 0) ? got_cyc[0] : -1, 20 + 1);
    chk("single_idle_valid", int'(out_valid_o), 0);

    // Back-to-back 0xB4, 0x1E -> 0,1,3,2,2,3,1,0.
    clear_log();
    push(8'hB4);
    push(8'h1E);
    for (int i = 0; i < 12; i++) cycle(1'b1);
    exp16 = '{0, 1, 3, 2, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("b2b", 8, exp16, 1'b1);
    chk("b2b_pops", pops, 2);

    // Backpressure: ready low for 3 cycles while the 2nd chunk is presented.
    clear_log();
    push(8'hB4);
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("stall_no_pop", pops, 1);
    for (int i = 0; i < 4; i++) cycle(1'b1);
    exp16 = '{0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("bp", 4, exp16, 1'b0);
    chk("bp_stall_hold", stall_hold, 3);
    chk("bp_pops", pops, 1);

    // Reset after the 2nd chunk of 0xB4, then 0x1E -> 2,3,1,0.
    clear_log();
    push(8'hB4);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    fifo_q.push_back(8'h55);
    drive_fifo();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    check_quiet("midword_reset");
    fifo_q.delete();
    rem.delete();
    drive_fifo();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    push(8'h1E);
    for (int i = 0; i < 8; i++) cycle(1'b1);
    exp16 = '{2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("post_reset", 4, exp16, 1'b1);

    // Full FIFO drain.
    clear_log();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    for (int i = 0; i < 22; i++) cycle(1'b1);
    exp16 = '{1, 0, 0, 0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0};
    check_seq("drain", 16, exp16, 1'b1);
    chk("drain_pops", pops, 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 4) push(DATA_W'($urandom));
      cycle($urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 30; i++) cycle(1'b1);
    chk("final_idle", int'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
